// File: rtl/axis_frame_length_adjust.sv
// -----------------------------------------------------------------------------
// axis_frame_length_adjust
//
// Purpose:
//   Byte-wide AXI4-Stream frame length adjuster. Frames shorter than
//   length_min are padded with 0x00 beats. Frames longer than length_max
//   are cut at length_max: the cut beat carries tlast and the rest of the
//   input frame is dropped. length_max == 0 means no upper limit. One status
//   record is produced per completed frame.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   s_axis_*                      input frame stream (8-bit data, no tkeep)
//   m_axis_*                      output frame stream, single register stage
//   length_min / length_max       length limits, sampled on each frame's first beat
//   status_valid                  one-cycle pulse per completed frame
//   status_frame_pad/_truncate    frame was padded / truncated
//   status_frame_length           output beats emitted for the frame
//   status_frame_original_length  input beats received (saturating)
// -----------------------------------------------------------------------------
module axis_frame_length_adjust #(
  parameter int ID_WIDTH   = 8,
  parameter int DEST_WIDTH = 8,
  parameter int USER_WIDTH = 1,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [7:0]            s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [ID_WIDTH-1:0]   s_axis_tid,
  input  logic [DEST_WIDTH-1:0] s_axis_tdest,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,

  output logic [7:0]            m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [ID_WIDTH-1:0]   m_axis_tid,
  output logic [DEST_WIDTH-1:0] m_axis_tdest,
  output logic [USER_WIDTH-1:0] m_axis_tuser,

  input  logic [LEN_WIDTH-1:0]  length_min,
  input  logic [LEN_WIDTH-1:0]  length_max,

  output logic                  status_valid,
  output logic                  status_frame_pad,
  output logic                  status_frame_truncate,
  output logic [LEN_WIDTH-1:0]  status_frame_length,
  output logic [LEN_WIDTH-1:0]  status_frame_original_length
);

  // State encodings
  localparam logic [1:0] ENC_TRANSFER = 2'd0;
  localparam logic [1:0] ENC_PAD      = 2'd1;
  localparam logic [1:0] ENC_TRUNCATE = 2'd2;

  typedef enum logic [1:0] {
    ST_TRANSFER = ENC_TRANSFER,
    ST_PAD      = ENC_PAD,
    ST_TRUNCATE = ENC_TRUNCATE
  } state_t;

  localparam logic [LEN_WIDTH-1:0] LEN_ZERO = {LEN_WIDTH{1'b0}};
  localparam logic [LEN_WIDTH-1:0] LEN_ONES = {LEN_WIDTH{1'b1}};
  localparam logic [LEN_WIDTH-1:0] LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [LEN_WIDTH-1:0] sat_inc(input logic [LEN_WIDTH-1:0] v);
    logic [LEN_WIDTH-1:0] r;
    if (v == LEN_ONES) begin
      r = v;
    end else begin
      r = v + LEN_ONE;
    end
    return r;
  endfunction

  // Control registers
  state_t                 state_q, state_d;
  logic [LEN_WIDTH-1:0]   in_cnt_q, in_cnt_d;
  logic [LEN_WIDTH-1:0]   out_cnt_q, out_cnt_d;
  logic [LEN_WIDTH-1:0]   len_min_q, len_min_d;
  logic [LEN_WIDTH-1:0]   len_max_q, len_max_d;
  logic                   m_tvalid_q, m_tvalid_d;
  logic                   status_valid_q, status_valid_d;
  logic                   status_pad_q, status_pad_d;
  logic                   status_trunc_q, status_trunc_d;
  logic [LEN_WIDTH-1:0]   status_len_q, status_len_d;
  logic [LEN_WIDTH-1:0]   status_orig_q, status_orig_d;

  // Data-path registers (no reset)
  logic [7:0]             m_tdata_q, m_tdata_d;
  logic                   m_tlast_q, m_tlast_d;
  logic [ID_WIDTH-1:0]    m_tid_q, m_tid_d;
  logic [DEST_WIDTH-1:0]  m_tdest_q, m_tdest_d;
  logic [USER_WIDTH-1:0]  m_tuser_q, m_tuser_d;

  // Combinational helpers
  logic                   load_s;
  logic                   first_s;
  logic                   s_tready_s;
  logic [LEN_WIDTH-1:0]   min_eff_s;
  logic [LEN_WIDTH-1:0]   max_eff_s;
  logic [LEN_WIDTH:0]     out_next_w_s;
  logic [LEN_WIDTH-1:0]   out_inc_s;
  logic [LEN_WIDTH-1:0]   in_inc_s;

  // Output register may load when empty or being drained this cycle.
  assign load_s = m_axis_tready || !m_tvalid_q;

  // Counters are zero only between frames, so this marks the first beat.
  assign first_s = (state_q == ST_TRANSFER) && (in_cnt_q == LEN_ZERO);

  // On the first beat the live limits apply; afterwards the latched copies.
  assign min_eff_s = first_s ? length_min : len_min_q;
  assign max_eff_s = first_s ? length_max : len_max_q;

  // One extra bit keeps out_cnt+1 comparisons free of wrap-around.
  assign out_next_w_s = {1'b0, out_cnt_q} + {{LEN_WIDTH{1'b0}}, 1'b1};
  assign out_inc_s    = sat_inc(out_cnt_q);
  assign in_inc_s     = sat_inc(in_cnt_q);

  // Next-state, counter, output-register and status computation.
  always_comb begin
    state_d        = state_q;
    in_cnt_d       = in_cnt_q;
    out_cnt_d      = out_cnt_q;
    len_min_d      = len_min_q;
    len_max_d      = len_max_q;
    m_tvalid_d     = m_tvalid_q;
    m_tdata_d      = m_tdata_q;
    m_tlast_d      = m_tlast_q;
    m_tid_d        = m_tid_q;
    m_tdest_d      = m_tdest_q;
    m_tuser_d      = m_tuser_q;
    status_valid_d = 1'b0;
    status_pad_d   = status_pad_q;
    status_trunc_d = status_trunc_q;
    status_len_d   = status_len_q;
    status_orig_d  = status_orig_q;
    s_tready_s     = 1'b0;

    case (state_q)
      ST_TRANSFER: begin
        s_tready_s = load_s;
        if (load_s) begin
          m_tvalid_d = 1'b0;
        end else begin
          m_tvalid_d = m_tvalid_q;
        end
        if (s_axis_tvalid && load_s) begin
          if (first_s) begin
            len_min_d = length_min;
            len_max_d = length_max;
          end else begin
            len_min_d = len_min_q;
            len_max_d = len_max_q;
          end
          m_tvalid_d = 1'b1;
          m_tdata_d  = s_axis_tdata;
          m_tid_d    = s_axis_tid;
          m_tdest_d  = s_axis_tdest;
          m_tuser_d  = s_axis_tuser;
          in_cnt_d   = in_inc_s;
          out_cnt_d  = out_inc_s;
          if (s_axis_tlast) begin
            if (out_next_w_s < {1'b0, min_eff_s}) begin
              // Short frame: hold back tlast and fill with pad beats.
              m_tlast_d = 1'b0;
              state_d   = ST_PAD;
            end else begin
              m_tlast_d      = 1'b1;
              status_valid_d = 1'b1;
              status_pad_d   = 1'b0;
              status_trunc_d = 1'b0;
              status_len_d   = out_inc_s;
              status_orig_d  = in_inc_s;
              in_cnt_d       = LEN_ZERO;
              out_cnt_d      = LEN_ZERO;
            end
          end else if ((max_eff_s != LEN_ZERO) && (out_next_w_s == {1'b0, max_eff_s})) begin
            // Long frame: close it here and swallow the remainder.
            m_tlast_d = 1'b1;
            state_d   = ST_TRUNCATE;
          end else begin
            m_tlast_d = 1'b0;
          end
        end else begin
          state_d = ST_TRANSFER;
        end
      end

      ST_PAD: begin
        s_tready_s = 1'b0;
        if (load_s) begin
          // tid/tdest/tuser stay as the last accepted beat left them.
          m_tvalid_d = 1'b1;
          m_tdata_d  = 8'h00;
          out_cnt_d  = out_inc_s;
          if (out_next_w_s == {1'b0, len_min_q}) begin
            m_tlast_d      = 1'b1;
            status_valid_d = 1'b1;
            status_pad_d   = 1'b1;
            status_trunc_d = 1'b0;
            status_len_d   = out_inc_s;
            status_orig_d  = in_cnt_q;
            in_cnt_d       = LEN_ZERO;
            out_cnt_d      = LEN_ZERO;
            state_d        = ST_TRANSFER;
          end else begin
            m_tlast_d = 1'b0;
          end
        end else begin
          state_d = ST_PAD;
        end
      end

      ST_TRUNCATE: begin
        s_tready_s = 1'b1;
        if (load_s) begin
          m_tvalid_d = 1'b0;
        end else begin
          m_tvalid_d = m_tvalid_q;
        end
        if (s_axis_tvalid) begin
          in_cnt_d = in_inc_s;
          if (s_axis_tlast) begin
            status_valid_d = 1'b1;
            status_pad_d   = 1'b0;
            status_trunc_d = 1'b1;
            status_len_d   = out_cnt_q;
            status_orig_d  = in_inc_s;
            in_cnt_d       = LEN_ZERO;
            out_cnt_d      = LEN_ZERO;
            state_d        = ST_TRANSFER;
          end else begin
            state_d = ST_TRUNCATE;
          end
        end else begin
          state_d = ST_TRUNCATE;
        end
      end

      default: begin
        state_d    = ST_TRANSFER;
        in_cnt_d   = LEN_ZERO;
        out_cnt_d  = LEN_ZERO;
        m_tvalid_d = 1'b0;
      end
    endcase
  end

  // Control and status registers; reset abandons any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_TRANSFER;
      in_cnt_q       <= LEN_ZERO;
      out_cnt_q      <= LEN_ZERO;
      len_min_q      <= LEN_ZERO;
      len_max_q      <= LEN_ZERO;
      m_tvalid_q     <= 1'b0;
      status_valid_q <= 1'b0;
      status_pad_q   <= 1'b0;
      status_trunc_q <= 1'b0;
      status_len_q   <= LEN_ZERO;
      status_orig_q  <= LEN_ZERO;
    end else begin
      state_q        <= state_d;
      in_cnt_q       <= in_cnt_d;
      out_cnt_q      <= out_cnt_d;
      len_min_q      <= len_min_d;
      len_max_q      <= len_max_d;
      m_tvalid_q     <= m_tvalid_d;
      status_valid_q <= status_valid_d;
      status_pad_q   <= status_pad_d;
      status_trunc_q <= status_trunc_d;
      status_len_q   <= status_len_d;
      status_orig_q  <= status_orig_d;
    end
  end

  // Output data path; qualified by m_axis_tvalid so it needs no reset.
  always_ff @(posedge clk) begin
    m_tdata_q <= m_tdata_d;
    m_tlast_q <= m_tlast_d;
    m_tid_q   <= m_tid_d;
    m_tdest_q <= m_tdest_d;
    m_tuser_q <= m_tuser_d;
  end

  assign s_axis_tready                = s_tready_s;
  assign m_axis_tdata                 = m_tdata_q;
  assign m_axis_tvalid                = m_tvalid_q;
  assign m_axis_tlast                 = m_tlast_q;
  assign m_axis_tid                   = m_tid_q;
  assign m_axis_tdest                 = m_tdest_q;
  assign m_axis_tuser                 = m_tuser_q;
  assign status_valid                 = status_valid_q;
  assign status_frame_pad             = status_pad_q;
  assign status_frame_truncate        = status_trunc_q;
  assign status_frame_length          = status_len_q;
  assign status_frame_original_length = status_orig_q;

endmodule
